// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the CPU instruction-side and data-side request ports
// onto a single external memory port.
//
// Each side pulses x_valid for one cycle; the request is captured into a
// holding register and marked pending. An FSM issues one external
// transaction at a time, waits for mem_ready and steers the response back
// to the owning side in the same cycle.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   imem_* (valid/instr/addr/wdata/wstrb in, rdata/ready out)  I-side port
//   dmem_* (valid/instr/addr/wdata/wstrb in, rdata/ready out)  D-side port
//   mem_*  (valid/instr/addr/wdata/wstrb out, rdata/ready in)  external port
//   protocol_err               sticky flag: second request while pending
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0   // 0 = round-robin, 1 = data side wins
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    imem_valid,
  input  logic                    imem_instr,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_wdata,
  input  logic [DATA_WIDTH/8-1:0] imem_wstrb,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_ready,
  input  logic                    dmem_valid,
  input  logic                    dmem_instr,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_ready,
  output logic                    mem_valid,
  output logic                    mem_instr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    protocol_err
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t                  state_reg;
  logic                    pend_i_reg, pend_d_reg;
  logic                    last_grant_reg;  // 0 = I, 1 = D
  logic                    protocol_err_reg;

  logic                    hold_i_instr_reg, hold_d_instr_reg;
  logic [ADDR_WIDTH-1:0]   hold_i_addr_reg,  hold_d_addr_reg;
  logic [DATA_WIDTH-1:0]   hold_i_wdata_reg, hold_d_wdata_reg;
  logic [SW-1:0]           hold_i_wstrb_reg, hold_d_wstrb_reg;

  logic issue, grant_d, done_i, done_d;

  // Outputs are gated by reset so the port is quiet during the reset cycle
  // even before the registers have been cleared by the edge.
  assign issue   = !reset && (state_reg == IDLE) && (pend_i_reg || pend_d_reg);
  // D wins when alone, in fixed-priority mode, or when I was granted last.
  assign grant_d = pend_d_reg && (!pend_i_reg || (ARB_MODE != 0) || !last_grant_reg);
  assign done_i  = !reset && (state_reg == WAIT_I) && mem_ready;
  assign done_d  = !reset && (state_reg == WAIT_D) && mem_ready;

  always_comb begin
    mem_valid  = issue;
    mem_instr  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if (issue) begin
      if (grant_d) begin
        mem_instr = hold_d_instr_reg;
        mem_addr  = hold_d_addr_reg;
        mem_wdata = hold_d_wdata_reg;
        mem_wstrb = hold_d_wstrb_reg;
      end else begin
        mem_instr = hold_i_instr_reg;
        mem_addr  = hold_i_addr_reg;
        mem_wdata = hold_i_wdata_reg;
        mem_wstrb = hold_i_wstrb_reg;
      end
    end
    imem_ready = done_i;
    imem_rdata = done_i ? mem_rdata : '0;
    dmem_ready = done_d;
    dmem_rdata = done_d ? mem_rdata : '0;
  end

  assign protocol_err = protocol_err_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      pend_i_reg       <= 1'b0;
      pend_d_reg       <= 1'b0;
      last_grant_reg   <= 1'b0;
      protocol_err_reg <= 1'b0;
      hold_i_instr_reg <= 1'b0;
      hold_i_addr_reg  <= '0;
      hold_i_wdata_reg <= '0;
      hold_i_wstrb_reg <= '0;
      hold_d_instr_reg <= 1'b0;
      hold_d_addr_reg  <= '0;
      hold_d_wdata_reg <= '0;
      hold_d_wstrb_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (issue) begin
            state_reg      <= grant_d ? WAIT_D : WAIT_I;
            last_grant_reg <= grant_d;
          end
        end
        WAIT_I:  if (mem_ready) state_reg <= IDLE;
        WAIT_D:  if (mem_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // A new request is legal when nothing is pending or the pending one
      // completes this very cycle; otherwise it is dropped and flagged.
      if (imem_valid) begin
        if (!pend_i_reg || done_i) begin
          pend_i_reg       <= 1'b1;
          hold_i_instr_reg <= imem_instr;
          hold_i_addr_reg  <= imem_addr;
          hold_i_wdata_reg <= imem_wdata;
          hold_i_wstrb_reg <= imem_wstrb;
        end else begin
          protocol_err_reg <= 1'b1;
        end
      end else if (done_i) begin
        pend_i_reg <= 1'b0;
      end

      if (dmem_valid) begin
        if (!pend_d_reg || done_d) begin
          pend_d_reg       <= 1'b1;
          hold_d_instr_reg <= dmem_instr;
          hold_d_addr_reg  <= dmem_addr;
          hold_d_wdata_reg <= dmem_wdata;
          hold_d_wstrb_reg <= dmem_wstrb;
        end else begin
          protocol_err_reg <= 1'b1;
        end
      end else if (done_d) begin
        pend_d_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Two instances share the stimulus:
// u_rr (round-robin) and u_fp (fixed priority, data side wins). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          imem_valid, imem_instr, dmem_valid, dmem_instr, mem_ready;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] imem_wdata, dmem_wdata, mem_rdata;
  logic [SW-1:0] imem_wstrb, dmem_wstrb;

  logic [DW-1:0] r_imem_rdata, r_dmem_rdata, f_imem_rdata, f_dmem_rdata;
  logic          r_imem_ready, r_dmem_ready, f_imem_ready, f_dmem_ready;
  logic          r_mem_valid, r_mem_instr, f_mem_valid, f_mem_instr;
  logic [AW-1:0] r_mem_addr, f_mem_addr;
  logic [DW-1:0] r_mem_wdata, f_mem_wdata;
  logic [SW-1:0] r_mem_wstrb, f_mem_wstrb;
  logic          r_protocol_err, f_protocol_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_rdata(r_imem_rdata), .imem_ready(r_imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(r_dmem_rdata), .dmem_ready(r_dmem_ready),
    .mem_valid(r_mem_valid), .mem_instr(r_mem_instr), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_wstrb(r_mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .protocol_err(r_protocol_err)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_rdata(f_imem_rdata), .imem_ready(f_imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(f_dmem_rdata), .dmem_ready(f_dmem_ready),
    .mem_valid(f_mem_valid), .mem_instr(f_mem_instr), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_wstrb(f_mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .protocol_err(f_protocol_err)
  );

  // Advance to the next cycle and return all request/response inputs to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    imem_valid = 0; imem_instr = 0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
    dmem_valid = 0; dmem_instr = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready  = 0; mem_rdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic req_i(input logic [AW-1:0] a, input logic tag);
    imem_valid = 1; imem_addr = a; imem_instr = tag;
  endtask

  task automatic req_d(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    dmem_valid = 1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws;
  endtask

  task automatic respond(input logic [DW-1:0] rd);
    mem_ready = 1; mem_rdata = rd;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    reset = 1;
    respond(32'hFFFF_FFFF);
    #1;
    total++; if (r_mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b want=0", r_mem_valid); end
    total++; if (r_imem_ready !== 1'b0 || r_dmem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b want=00", r_imem_ready, r_dmem_ready); end
    total++; if (r_mem_addr !== '0 || r_imem_rdata !== '0 || r_dmem_rdata !== '0) begin bad++; $display("FAIL reset_data addr=%h ir=%h dr=%h want=0", r_mem_addr, r_imem_rdata, r_dmem_rdata); end
    total++; if (r_protocol_err !== 1'b0 || f_protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", r_protocol_err, f_protocol_err); end
    tick();
    reset = 0;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    req_d(32'h100, 32'h0, 4'h0);                            // cycle 1
    #1;
    total++; if (r_mem_valid !== 1'b0) begin bad++; $display("FAIL single_c1_valid got=%b want=0", r_mem_valid); end
    tick();                                                  // cycle 2
    #1;
    total++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h100 || r_mem_wstrb !== 4'h0) begin bad++; $display("FAIL single_issue valid=%b addr=%h strb=%h want 1/100/0", r_mem_valid, r_mem_addr, r_mem_wstrb); end
    tick();                                                  // cycle 3
    #1;
    total++; if (r_mem_valid !== 1'b0 || r_mem_addr !== '0) begin bad++; $display("FAIL single_wait valid=%b addr=%h want 0/0", r_mem_valid, r_mem_addr); end
    tick();                                                  // cycle 4
    respond(32'hDEAD_BEEF);
    #1;
    total++; if (r_dmem_ready !== 1'b1 || r_dmem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_resp ready=%b rdata=%h want 1/deadbeef", r_dmem_ready, r_dmem_rdata); end
    total++; if (r_imem_ready !== 1'b0 || r_imem_rdata !== '0) begin bad++; $display("FAIL single_iside ready=%b rdata=%h want 0/0", r_imem_ready, r_imem_rdata); end
    tick();                                                  // cycle 5
    #1;
    total++; if (r_dmem_ready !== 1'b0 || r_mem_valid !== 1'b0) begin bad++; $display("FAIL single_after ready=%b valid=%b want 0/0", r_dmem_ready, r_mem_valid); end
    $display("test_single_read done");
  endtask

  task automatic test_rr_tie();
    do_reset();
    req_i(32'h0, 1'b1);                                      // cycle 1
    req_d(32'h2000, 32'h1234_5678, 4'hF);
    tick();                                                  // cycle 2
    #1;
    total++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h2000 || r_mem_wdata !== 32'h1234_5678 || r_mem_wstrb !== 4'hF) begin bad++; $display("FAIL rr_tie1_d valid=%b addr=%h wd=%h strb=%h", r_mem_valid, r_mem_addr, r_mem_wdata, r_mem_wstrb); end
    tick();                                                  // cycle 3
    respond(32'h0000_A5A5);
    #1;
    total++; if (r_dmem_ready !== 1'b1 || r_imem_ready !== 1'b0 || r_mem_valid !== 1'b0) begin bad++; $display("FAIL rr_tie1_resp d=%b i=%b valid=%b want 1/0/0", r_dmem_ready, r_imem_ready, r_mem_valid); end
    tick();                                                  // cycle 4
    #1;
    total++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h0 || r_mem_instr !== 1'b1) begin bad++; $display("FAIL rr_tie1_i valid=%b addr=%h instr=%b want 1/0/1", r_mem_valid, r_mem_addr, r_mem_instr); end
    tick();                                                  // cycle 5
    respond(32'h0000_1111);
    #1;
    total++; if (r_imem_ready !== 1'b1 || r_imem_rdata !== 32'h1111 || r_dmem_rdata !== '0) begin bad++; $display("FAIL rr_tie1_iresp ready=%b ir=%h dr=%h", r_imem_ready, r_imem_rdata, r_dmem_rdata); end
    tick();                                                  // cycle 6: lone D makes D the last grant
    req_d(32'h300, 32'h0, 4'h0);
    tick();                                                  // cycle 7
    tick();                                                  // cycle 8
    respond(32'h0);
    tick();                                                  // cycle 9
    req_i(32'h40, 1'b1);
    req_d(32'h50, 32'h0, 4'h0);
    tick();                                                  // cycle 10
    #1;
    total++; if (r_mem_addr !== 32'h40 || r_mem_valid !== 1'b1) begin bad++; $display("FAIL rr_tie2_i addr=%h valid=%b want 40/1", r_mem_addr, r_mem_valid); end
    total++; if (f_mem_addr !== 32'h50 || f_mem_valid !== 1'b1) begin bad++; $display("FAIL fp_tie_d addr=%h valid=%b want 50/1", f_mem_addr, f_mem_valid); end
    tick();                                                  // cycle 11
    respond(32'h0);
    tick();                                                  // cycle 12
    #1;
    total++; if (r_mem_addr !== 32'h50 || r_mem_valid !== 1'b1) begin bad++; $display("FAIL rr_tie2_d addr=%h valid=%b want 50/1", r_mem_addr, r_mem_valid); end
    total++; if (f_mem_addr !== 32'h40 || f_mem_valid !== 1'b1) begin bad++; $display("FAIL fp_tie_i addr=%h valid=%b want 40/1", f_mem_addr, f_mem_valid); end
    tick();                                                  // cycle 13
    respond(32'h0);
    tick();
    $display("test_rr_tie done");
  endtask

  task automatic test_fixed_starvation();
    do_reset();
    req_i(32'h10, 1'b1);                                     // cycle 1
    req_d(32'h20, 32'h0, 4'h0);
    tick();                                                  // cycle 2
    #1;
    total++; if (f_mem_addr !== 32'h20 || f_mem_valid !== 1'b1) begin bad++; $display("FAIL fp_starve_1 addr=%h valid=%b want 20/1", f_mem_addr, f_mem_valid); end
    tick();                                                  // cycle 3
    respond(32'h0);
    req_d(32'h24, 32'h0, 4'h0);
    #1;
    total++; if (f_dmem_ready !== 1'b1) begin bad++; $display("FAIL fp_starve_resp1 got=%b want=1", f_dmem_ready); end
    tick();                                                  // cycle 4
    #1;
    total++; if (f_mem_addr !== 32'h24 || f_mem_valid !== 1'b1) begin bad++; $display("FAIL fp_starve_2 addr=%h valid=%b want 24/1", f_mem_addr, f_mem_valid); end
    total++; if (r_mem_addr !== 32'h10) begin bad++; $display("FAIL rr_no_starve addr=%h want 10", r_mem_addr); end
    tick();                                                  // cycle 5
    respond(32'h0);
    req_d(32'h28, 32'h0, 4'h0);
    tick();                                                  // cycle 6
    #1;
    total++; if (f_mem_addr !== 32'h28 || f_mem_valid !== 1'b1) begin bad++; $display("FAIL fp_starve_3 addr=%h valid=%b want 28/1", f_mem_addr, f_mem_valid); end
    tick();                                                  // cycle 7
    respond(32'h0);
    tick();                                                  // cycle 8
    #1;
    total++; if (f_mem_addr !== 32'h10 || f_mem_valid !== 1'b1 || f_mem_instr !== 1'b1) begin bad++; $display("FAIL fp_starve_i addr=%h valid=%b instr=%b want 10/1/1", f_mem_addr, f_mem_valid, f_mem_instr); end
    tick();                                                  // cycle 9
    respond(32'h0000_7777);
    #1;
    total++; if (f_imem_ready !== 1'b1 || f_imem_rdata !== 32'h7777 || f_protocol_err !== 1'b0) begin bad++; $display("FAIL fp_starve_iresp ready=%b rdata=%h err=%b", f_imem_ready, f_imem_rdata, f_protocol_err); end
    tick();
    $display("test_fixed_starvation done");
  endtask

  task automatic test_protocol_err();
    do_reset();
    req_i(32'h500, 1'b1);                                    // cycle 1
    tick();                                                  // cycle 2
    req_i(32'h600, 1'b1);
    #1;
    total++; if (r_protocol_err !== 1'b0 || r_mem_addr !== 32'h500) begin bad++; $display("FAIL perr_c2 err=%b addr=%h want 0/500", r_protocol_err, r_mem_addr); end
    tick();                                                  // cycle 3
    #1;
    total++; if (r_protocol_err !== 1'b1 || r_mem_valid !== 1'b0) begin bad++; $display("FAIL perr_c3 err=%b valid=%b want 1/0", r_protocol_err, r_mem_valid); end
    tick();                                                  // cycle 4
    respond(32'h0000_0055);
    #1;
    total++; if (r_imem_ready !== 1'b1 || r_imem_rdata !== 32'h55) begin bad++; $display("FAIL perr_resp ready=%b rdata=%h want 1/55", r_imem_ready, r_imem_rdata); end
    tick();                                                  // cycle 5
    #1;
    total++; if (r_mem_valid !== 1'b0 || r_protocol_err !== 1'b1) begin bad++; $display("FAIL perr_dropped valid=%b err=%b want 0/1", r_mem_valid, r_protocol_err); end
    tick();                                                  // cycle 6
    #1;
    total++; if (r_mem_valid !== 1'b0 || r_protocol_err !== 1'b1) begin bad++; $display("FAIL perr_sticky valid=%b err=%b want 0/1", r_mem_valid, r_protocol_err); end
    $display("test_protocol_err done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_d(32'h700, 32'h0, 4'h0);                             // cycle 1
    tick();                                                  // cycle 2
    tick();                                                  // cycle 3
    respond(32'h0000_0A0A);
    req_d(32'h704, 32'hCAFE_0001, 4'h3);
    #1;
    total++; if (r_dmem_ready !== 1'b1 || r_dmem_rdata !== 32'h0A0A) begin bad++; $display("FAIL b2b_resp ready=%b rdata=%h want 1/0a0a", r_dmem_ready, r_dmem_rdata); end
    tick();                                                  // cycle 4
    #1;
    total++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h704 || r_mem_wdata !== 32'hCAFE_0001 || r_mem_wstrb !== 4'h3) begin bad++; $display("FAIL b2b_issue valid=%b addr=%h wd=%h strb=%h", r_mem_valid, r_mem_addr, r_mem_wdata, r_mem_wstrb); end
    total++; if (r_protocol_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", r_protocol_err); end
    tick();                                                  // cycle 5
    respond(32'h0);
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i(32'h800, 1'b0);                                    // cycle 1
    tick();                                                  // cycle 2 issue
    #1;
    total++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h800) begin bad++; $display("FAIL rmid_issue valid=%b addr=%h want 1/800", r_mem_valid, r_mem_addr); end
    tick();                                                  // cycle 3 in WAIT_I
    reset = 1;
    tick();                                                  // cycle 4
    reset = 0;
    respond(32'h0000_0BAD);
    #1;
    total++; if (r_imem_ready !== 1'b0 || r_imem_rdata !== '0 || r_mem_valid !== 1'b0) begin bad++; $display("FAIL rmid_late ready=%b rdata=%h valid=%b want 0/0/0", r_imem_ready, r_imem_rdata, r_mem_valid); end
    tick();                                                  // cycle 5
    #1;
    total++; if (r_mem_valid !== 1'b0 || r_imem_ready !== 1'b0) begin bad++; $display("FAIL rmid_idle valid=%b ready=%b want 0/0", r_mem_valid, r_imem_ready); end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1;
    imem_valid = 0; imem_instr = 0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
    dmem_valid = 0; dmem_instr = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready  = 0; mem_rdata  = '0;
    test_reset();
    test_single_read();
    test_rr_tie();
    test_fixed_starvation();
    test_protocol_err();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Merges the CPU's instruction and data memory request ports into one external memory port.
- Sits directly downstream of the cpu top-level and upstream of the system memory/bus.
- Captures single-cycle requests from each side into holding registers and arbitrates between them.
- Issues one transaction at a time and steers the response back to the requester that owns it.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- ARB_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, data side wins

Ports:
- reset  in  1  synchronous, active-high
- clock  in  1  single clock; all state updates on rising edge
- imem_valid  in  1  instruction-side request pulse (one cycle)
- imem_instr  in  1  request-is-fetch tag, forwarded unchanged
- imem_addr  in  ADDR_WIDTH  request address
- imem_wdata  in  DATA_WIDTH  write data
- imem_wstrb  in  DATA_WIDTH/8  byte strobes; 0 = read
- imem_rdata  out  DATA_WIDTH  response data
- imem_ready  out  1  response pulse (one cycle)
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb  in  same widths as imem_*  data-side request
- dmem_rdata  out  DATA_WIDTH  data-side response data
- dmem_ready  out  1  data-side response pulse
- mem_valid  out  1  external request pulse
- mem_instr  out  1  forwarded tag
- mem_addr  out  ADDR_WIDTH  forwarded address
- mem_wdata  out  DATA_WIDTH  forwarded write data
- mem_wstrb  out  DATA_WIDTH/8  forwarded strobes
- mem_rdata  in  DATA_WIDTH  external response data
- mem_ready  in  1  external response pulse
- protocol_err  out  1  sticky; set on an illegal second request while one is pending

Behaviour:

Protocol:
- Each requester pulses valid for one cycle with its fields.
- Each requester has at most one outstanding request; it waits for its ready pulse before issuing another.

Capture:
- An x_valid at cycle N loads hold_x (addr, wdata, wstrb, instr) and sets pend_x at edge N.
- A valid on a side whose pend_x=1 that is not completing this cycle is dropped, and protocol_err is set.
- A valid in the same cycle that side's ready is pulsed is legal and is captured.

State machine (IDLE, WAIT_I, WAIT_D):
- IDLE, no pending request: mem_valid=0.
- IDLE, exactly one side pending: mem_valid=1 combinationally, fields muxed from that side's hold register; next state WAIT_x.
- IDLE, both sides pending:
  - ARB_MODE=1: D is granted.
  - ARB_MODE=0: the side not in last_grant is granted. last_grant updates on every issue and resets to I, so D wins the first tie.
- WAIT_x: mem_valid=0; mem_ready is sampled.
  - On mem_ready=1: x_ready=1 and x_rdata=mem_rdata in the same cycle (combinational); pend_x clears; next state IDLE.
- mem_ready is ignored in IDLE and in the issue cycle.

Timing:
- Minimum request-to-issue latency: 1 cycle. A request at N gives mem_valid at N+1.
- Minimum issue-to-issue spacing: 2 cycles.
- Response latency adds 0 cycles.

Output rules:
- Non-owning side: ready=0, rdata=0.
- mem_addr, mem_wdata, mem_wstrb and mem_instr are 0 when mem_valid=0.

Reset (any cycle, including mid-WAIT):
- state=IDLE, pend_i=pend_d=0, hold registers=0, last_grant=I, protocol_err=0.
- All outputs 0.
- A late mem_ready arriving after reset is ignored.

Test Plan:
- Single read: dmem_valid, addr=0x100, wstrb=0 at cycle 1 -> mem_valid at cycle 2 with addr 0x100; mem_ready, rdata=0xDEADBEEF at cycle 4 -> dmem_ready=1, dmem_rdata=0xDEADBEEF at cycle 4; imem_ready stays 0.
- Simultaneous requests, ARB_MODE=0: I addr=0x0 and D addr=0x2000 (wstrb=0xF, wdata=0x12345678) both at cycle 1 -> D issued at cycle 2; after mem_ready at 3, I issued at 4. A second simultaneous pair then grants I first.
- ARB_MODE=1 starvation check: D re-requests on every completion cycle while I is pending -> D is always granted; I issues only once D stops requesting.
- Protocol error: imem_valid at 1 and again at 2 before any response -> protocol_err=1 from cycle 3 onward; the second request is not issued.
- Back-to-back on the same side: dmem_valid in the same cycle as dmem_ready -> new request captured; mem_valid asserted on the next cycle.
- Reset mid-transaction: reset in WAIT_I, then mem_ready=1 the cycle after reset deasserts -> imem_ready=0, mem_valid=0, state IDLE.
